// File: rtl/fb_pkg.sv
// Shared framebuffer geometry, writer FSM states and the {y, x} address layout
// used by both the write side and the display read side.
package fb_pkg;

  localparam int COLUMNS      = 64;
  localparam int ROWS         = 64;
  localparam int COLOR_WIDTH  = 4;
  localparam int ADDR_WIDTH   = 12;
  localparam int X_WIDTH      = 6;
  localparam int Y_WIDTH      = 6;
  localparam int FRAME_PIXELS = COLUMNS * ROWS;
  localparam int CNT_WIDTH    = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } fb_state_t;

  // y[5] picks the panel half, y[4:0] the row, x the column.
  function automatic logic [ADDR_WIDTH-1:0] pack_addr(input logic [X_WIDTH-1:0] x,
                                                      input logic [Y_WIDTH-1:0] y);
    return {y, x};
  endfunction

  function automatic logic in_range(input logic [X_WIDTH-1:0] x,
                                    input logic [Y_WIDTH-1:0] y);
    return (int'(x) < COLUMNS) && (int'(y) < ROWS);
  endfunction

endpackage

// File: rtl/fb_writer.sv
// Framebuffer write-side controller: single-pixel writes over valid/ready and a
// hardware full-frame fill sweep, all framebuffer outputs registered.
module fb_writer
  import fb_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   px_valid,
  output logic                   px_ready,
  input  logic [X_WIDTH-1:0]     px_x,
  input  logic [Y_WIDTH-1:0]     px_y,
  input  logic [COLOR_WIDTH-1:0] px_color,
  output logic                   px_dropped,
  input  logic                   fill_start,
  input  logic [COLOR_WIDTH-1:0] fill_color,
  output logic                   busy,
  output logic                   fill_done,
  output logic [ADDR_WIDTH-1:0]  fb_waddr,
  output logic [COLOR_WIDTH-1:0] fb_din,
  output logic                   fb_we,
  output logic                   fb_ce
);

  localparam logic [CNT_WIDTH-1:0] LAST_ADDR = CNT_WIDTH'(FRAME_PIXELS - 1);

  fb_state_t              state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [COLOR_WIDTH-1:0] fill_color_q, fill_color_d;
  logic                   we_q, we_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [COLOR_WIDTH-1:0] din_q, din_d;
  logic                   dropped_q, dropped_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   px_fire;

  // A simultaneous fill request wins, so ready drops combinationally.
  assign px_ready = rst && (state_q == IDLE) && !fill_start;
  assign px_fire  = px_valid && px_ready;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    fill_color_d = fill_color_q;
    we_d         = 1'b0;
    addr_d       = addr_q;
    din_d        = din_q;
    dropped_d    = 1'b0;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (fill_start) begin
          state_d      = FILL;
          cnt_d        = '0;
          fill_color_d = fill_color;
          we_d         = 1'b1;
          addr_d       = '0;
          din_d        = fill_color;
          busy_d       = 1'b1;
        end else if (px_fire) begin
          if (in_range(px_x, px_y)) begin
            we_d   = 1'b1;
            addr_d = pack_addr(px_x, px_y);
            din_d  = px_color;
          end else begin
            dropped_d = 1'b1;
          end
        end
      end
      // cnt_q always equals the address currently presented on fb_waddr.
      FILL: begin
        if (cnt_q == LAST_ADDR) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          cnt_d  = cnt_q + 1'b1;
          we_d   = 1'b1;
          addr_d = ADDR_WIDTH'(cnt_q + 1'b1);
          din_d  = fill_color_q;
          busy_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      fill_color_q <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      din_q        <= '0;
      dropped_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      fill_color_q <= fill_color_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      din_q        <= din_d;
      dropped_q    <= dropped_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign fb_we      = we_q;
  assign fb_waddr   = addr_q;
  assign fb_din     = din_q;
  assign px_dropped = dropped_q;
  assign busy       = busy_q;
  assign fill_done  = done_q;
  assign fb_ce      = 1'b1;

endmodule

// File: tb/tb_fb_writer.sv
// Self-checking bench for fb_writer: timeline reference model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_fb_writer;
  import fb_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       px_valid = 1'b0;
  logic [5:0] px_x = '0;
  logic [5:0] px_y = '0;
  logic [3:0] px_color = '0;
  logic       fill_start = 1'b0;
  logic [3:0] fill_color = '0;
  logic        px_ready, px_dropped, busy, fill_done, fb_we, fb_ce;
  logic [11:0] fb_waddr;
  logic [3:0]  fb_din;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fb_writer dut (
    .clk(clk), .rst(rst),
    .px_valid(px_valid), .px_ready(px_ready),
    .px_x(px_x), .px_y(px_y), .px_color(px_color),
    .px_dropped(px_dropped),
    .fill_start(fill_start), .fill_color(fill_color),
    .busy(busy), .fill_done(fill_done),
    .fb_waddr(fb_waddr), .fb_din(fb_din), .fb_we(fb_we), .fb_ce(fb_ce)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  // Reference model: a fill accepted at clock edge E writes address k during
  // the cycle after edge E+k (k = 0..4095) and reports completion after E+4096.
  int         edge_n = 0;
  int         fill_edge = -100000;
  logic [3:0] m_fill_col = '0;
  bit         m_pix = 0;
  bit         m_inr = 0;
  logic [11:0] m_addr = '0;
  logic [3:0] m_col = '0;
  bit         m_idle;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      fill_edge = -100000;
      m_pix     = 0;
    end else begin
      m_idle = (edge_n - fill_edge) > FRAME_PIXELS;
      edge_n++;
      m_pix = 0;
      if (m_idle && fill_start) begin
        fill_edge  = edge_n;
        m_fill_col = fill_color;
      end else if (m_idle && px_valid) begin
        m_pix  = 1;
        m_inr  = (int'(px_x) < COLUMNS) && (int'(px_y) < ROWS);
        m_addr = 12'(int'(px_y) * COLUMNS + int'(px_x));
        m_col  = px_color;
      end
    end
  end

  int cnt_busy = 0, cnt_fwe = 0, cnt_done = 0;
  int age;
  bit e_busy, e_done, e_we, e_drop, e_ready;
  logic [11:0] e_addr;
  logic [3:0]  e_din;
  logic [21:0] exp_v, act_v;

  always @(negedge clk) begin
    if (rst) begin
      age     = edge_n - fill_edge;
      e_busy  = (age >= 0) && (age < FRAME_PIXELS);
      e_done  = (age == FRAME_PIXELS);
      e_we    = e_busy || (m_pix && m_inr);
      e_drop  = m_pix && !m_inr;
      e_ready = (age > FRAME_PIXELS) && !fill_start;
      e_addr  = e_busy ? 12'(age) : (e_we ? m_addr : 12'h0);
      e_din   = e_busy ? m_fill_col : (e_we ? m_col : 4'h0);
      exp_v = {e_ready, e_busy, e_done, e_drop, e_we, 1'b1, e_addr, e_din};
      act_v = {px_ready, busy, fill_done, px_dropped, fb_we, fb_ce,
               (e_we ? fb_waddr : 12'h0), (e_we ? fb_din : 4'h0)};
      chk("cycle", 32'(act_v), 32'(exp_v));
      if (busy) cnt_busy++;
      if (busy && fb_we) cnt_fwe++;
      if (fill_done) cnt_done++;
    end
  end

  task automatic wait_done(input string nm);
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (fill_done) break;
    end
    #1;
    chk(nm, 32'(fill_done), 32'd1);
  endtask

  task automatic wait_addr(input string nm, input int a);
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (busy && fb_waddr == 12'(a)) break;
    end
    chk(nm, 32'(fb_waddr), 32'(a));
  endtask

  int b0, w0, d0;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_we", 32'(fb_we), 0);
    chk("rst_waddr", 32'(fb_waddr), 0);
    chk("rst_din", 32'(fb_din), 0);
    chk("rst_ce", 32'(fb_ce), 1);
    chk("rst_ready", 32'(px_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(fill_done), 0);
    chk("rst_drop", 32'(px_dropped), 0);
    @(negedge clk); #1 rst = 1'b1;

    // Single pixel
    @(posedge clk); #1 px_valid = 1; px_x = 5; px_y = 3; px_color = 4'hA;
    @(negedge clk); chk("p1_ready", 32'(px_ready), 1);
    @(posedge clk); #1 px_valid = 0;
    @(negedge clk);
    chk("p1_we", 32'(fb_we), 1);
    chk("p1_addr", 32'(fb_waddr), 32'h0C5);
    chk("p1_din", 32'(fb_din), 32'hA);
    @(negedge clk); chk("p1_we_off", 32'(fb_we), 0);

    // Back-to-back pixels
    @(posedge clk); #1 px_valid = 1; px_x = 63; px_y = 63; px_color = 4'hF;
    @(negedge clk); chk("b2b_ready0", 32'(px_ready), 1);
    @(posedge clk); #1 px_x = 0; px_y = 32; px_color = 4'h1;
    @(negedge clk);
    chk("b2b_ready1", 32'(px_ready), 1);
    chk("b2b_addr0", 32'(fb_waddr), 32'hFFF);
    chk("b2b_din0", 32'(fb_din), 32'hF);
    @(posedge clk); #1 px_valid = 0;
    @(negedge clk);
    chk("b2b_we1", 32'(fb_we), 1);
    chk("b2b_addr1", 32'(fb_waddr), 32'h800);
    chk("b2b_din1", 32'(fb_din), 32'h1);

    // Full fill with colour 3
    @(posedge clk); #1 fill_start = 1; fill_color = 4'h3;
    @(negedge clk); chk("fill_ready_low", 32'(px_ready), 0);
    @(posedge clk); #1 fill_start = 0; fill_color = 4'hE;
    b0 = cnt_busy; w0 = cnt_fwe; d0 = cnt_done;
    wait_done("fill_done_seen");
    chk("fill_busy_cycles", 32'(cnt_busy - b0), 32'd4096);
    chk("fill_we_cycles", 32'(cnt_fwe - w0), 32'd4096);
    chk("fill_done_count", 32'(cnt_done - d0), 32'd1);
    chk("fill_ready_at_done", 32'(px_ready), 0);
    @(negedge clk); chk("fill_ready_back", 32'(px_ready), 1);

    // Fill and pixel requested together; pixel held until after the sweep
    @(posedge clk); #1 px_valid = 1; px_x = 10; px_y = 40; px_color = 4'h7;
    fill_start = 1; fill_color = 4'hC;
    @(negedge clk); chk("coll_ready", 32'(px_ready), 0);
    @(posedge clk); #1 fill_start = 0;
    wait_done("coll_done_seen");
    @(negedge clk); chk("coll_ready_back", 32'(px_ready), 1);
    @(posedge clk); #1 px_valid = 0;
    @(negedge clk);
    chk("coll_we", 32'(fb_we), 1);
    chk("coll_addr", 32'(fb_waddr), 32'hA0A);
    chk("coll_din", 32'(fb_din), 32'h7);

    // Second fill_start mid-sweep is ignored
    @(posedge clk); #1 fill_start = 1; fill_color = 4'h5;
    @(posedge clk); #1 fill_start = 0;
    b0 = cnt_busy; w0 = cnt_fwe; d0 = cnt_done;
    wait_addr("f2_at100", 100);
    @(posedge clk); #1 fill_start = 1; fill_color = 4'h6;
    @(posedge clk); #1 fill_start = 0;
    wait_done("f2_done_seen");
    chk("f2_we_cycles", 32'(cnt_fwe - w0), 32'd4096);
    repeat (20) @(negedge clk);
    #1;
    chk("f2_done_count", 32'(cnt_done - d0), 32'd1);
    chk("f2_busy_total", 32'(cnt_busy - b0), 32'd4096);

    // Reset in the middle of a sweep
    @(posedge clk); #1 fill_start = 1; fill_color = 4'h9;
    @(posedge clk); #1 fill_start = 0;
    d0 = cnt_done;
    wait_addr("rst_at2000", 2000);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_we", 32'(fb_we), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_done", 32'(fill_done), 0);
    chk("mid_rst_ready", 32'(px_ready), 0);
    @(posedge clk);
    @(negedge clk); #1 rst = 1'b1;
    @(negedge clk); chk("post_rst_ready", 32'(px_ready), 1);
    repeat (10) @(negedge clk);
    #1;
    chk("post_rst_no_done", 32'(cnt_done - d0), 0);

    // Random traffic
    for (int i = 0; i < 8000; i++) begin
      @(posedge clk); #1;
      px_valid   = ($urandom_range(0, 9) < 7);
      px_x       = 6'($urandom);
      px_y       = 6'($urandom);
      px_color   = 4'($urandom);
      fill_start = ($urandom_range(0, 1499) == 0);
      fill_color = 4'($urandom);
    end
    @(posedge clk); #1 px_valid = 0; fill_start = 0;
    repeat (4200) @(posedge clk);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
